// File: rtl/partition_sweep_meter_if.sv
// Signal bundle between the sweep meter and the partition pair it measures.
// The master side is the meter; the slave side supplies start and the two partition responses.
interface partition_sweep_meter_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
);
  localparam int MM_W = IN_W + 1;
  localparam int BE_W = IN_W + $clog2(OUT_W) + 1;
  localparam int SA_W = IN_W + OUT_W;

  logic              start;
  logic [IN_W-1:0]   pi_out;
  logic [OUT_W-1:0]  po_exact;
  logic [OUT_W-1:0]  po_approx;
  logic              busy;
  logic              done;
  logic [MM_W-1:0]   mismatch_cnt;
  logic [BE_W-1:0]   bit_err_cnt;
  logic [OUT_W-1:0]  max_abs_err;
  logic [SA_W-1:0]   sum_abs_err;

  modport master (
    input  start, po_exact, po_approx,
    output pi_out, busy, done, mismatch_cnt, bit_err_cnt, max_abs_err, sum_abs_err
  );

  modport slave (
    output start, po_exact, po_approx,
    input  pi_out, busy, done, mismatch_cnt, bit_err_cnt, max_abs_err, sum_abs_err
  );
endinterface

// File: rtl/partition_sweep_meter.sv
// Exhaustively sweeps a partition input space and accumulates error metrics between an exact
// and an approximate implementation driven by the same vector, through a two-stage pipeline.
module partition_sweep_meter #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  partition_sweep_meter_if.master  bus
);
  localparam int MM_W = IN_W + 1;
  localparam int BE_W = IN_W + $clog2(OUT_W) + 1;
  localparam int SA_W = IN_W + OUT_W;
  localparam int PC_W = $clog2(OUT_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [IN_W-1:0]  pi_q,         pi_d;
  logic [OUT_W-1:0] cmp_exact_q,  cmp_exact_d;
  logic [OUT_W-1:0] cmp_approx_q, cmp_approx_d;
  logic             cmp_vld_q,    cmp_vld_d;
  logic [MM_W-1:0]  mm_q,         mm_d;
  logic [BE_W-1:0]  be_q,         be_d;
  logic [OUT_W-1:0] max_q,        max_d;
  logic [SA_W-1:0]  sum_q,        sum_d;

  logic [OUT_W:0]   diff_wide;
  logic [OUT_W:0]   abs_wide;
  logic [OUT_W-1:0] abs_err;
  logic [OUT_W-1:0] xor_bits;
  logic [PC_W-1:0]  pop_cnt;

  // Stage 2: metrics of the pair held in the compare register.
  always_comb begin
    diff_wide = {1'b0, cmp_exact_q} - {1'b0, cmp_approx_q};
    abs_wide  = diff_wide[OUT_W] ? -diff_wide : diff_wide;
    // |a-b| of two OUT_W-bit unsigned values always fits in OUT_W bits.
    abs_err   = abs_wide[OUT_W-1:0];
    xor_bits  = cmp_exact_q ^ cmp_approx_q;
    pop_cnt   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      pop_cnt = pop_cnt + PC_W'(xor_bits[i]);
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d      = state_q;
    pi_d         = pi_q;
    cmp_exact_d  = cmp_exact_q;
    cmp_approx_d = cmp_approx_q;
    cmp_vld_d    = cmp_vld_q;
    mm_d         = mm_q;
    be_d         = be_q;
    max_d        = max_q;
    sum_d        = sum_q;

    if (cmp_vld_q) begin
      mm_d  = mm_q + MM_W'(xor_bits != '0);
      be_d  = be_q + BE_W'(pop_cnt);
      sum_d = sum_q + SA_W'(abs_err);
      max_d = (abs_err > max_q) ? abs_err : max_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_SWEEP;
          pi_d         = '0;
          cmp_exact_d  = '0;
          cmp_approx_d = '0;
          cmp_vld_d    = 1'b0;
          mm_d         = '0;
          be_d         = '0;
          max_d        = '0;
          sum_d        = '0;
        end
      end
      S_SWEEP: begin
        cmp_exact_d  = bus.po_exact;
        cmp_approx_d = bus.po_approx;
        cmp_vld_d    = 1'b1;
        // The last vector rolls pi over to zero, where it stays until the next start.
        pi_d         = pi_q + IN_W'(1);
        if (pi_q == '1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cmp_vld_d = 1'b0;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pi_q         <= '0;
      cmp_exact_q  <= '0;
      cmp_approx_q <= '0;
      cmp_vld_q    <= 1'b0;
      mm_q         <= '0;
      be_q         <= '0;
      max_q        <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      pi_q         <= pi_d;
      cmp_exact_q  <= cmp_exact_d;
      cmp_approx_q <= cmp_approx_d;
      cmp_vld_q    <= cmp_vld_d;
      mm_q         <= mm_d;
      be_q         <= be_d;
      max_q        <= max_d;
      sum_q        <= sum_d;
    end
  end

  assign bus.pi_out       = pi_q;
  assign bus.busy         = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign bus.done         = (state_q == S_DONE);
  assign bus.mismatch_cnt = mm_q;
  assign bus.bit_err_cnt  = be_q;
  assign bus.max_abs_err  = max_q;
  assign bus.sum_abs_err  = sum_q;
endmodule
